// File: rtl/nios2_debug_ocimem_seq.sv
// nios2_debug_ocimem_seq
//   Sysclk-domain OCI-memory sequencer. Converts the one-cycle take_action /
//   take_no_action strobes and the 38-bit jdo word into single-beat
//   read/write transactions on the debug memory port. It also handles
//   address auto-increment and the waitrequest handshake, and drives
//   MonDReg / monitor_ready / monitor_error back toward the TCK-side
//   capture logic.
//
//   Optional feature macro: NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
//     When this macro is defined, a transaction that stalls for TIMEOUT_CYC
//     cycles is aborted. The abort sets the sticky monitor_error flag and
//     loads MonDReg with 32'hDEADBEEF on reads. When the macro is undefined,
//     transactions wait indefinitely and monitor_error is tied low.
//
// Ports:
//   clk, reset_n                   system clock, synchronous active-low reset
//   jdo[37:0]                      JTAG data-out word, valid with any strobe
//   take_action_ocimem_a           load address from jdo[17 +: ADDR_W];
//                                  jdo[35] also starts a read; jdo[36]
//                                  clears monitor_error
//   take_no_action_ocimem_a        read at the current address, then increment
//   take_action_ocimem_b           write jdo[34:3] at the current address,
//                                  then increment
//   mem_rdata, mem_waitrequest     debug memory response
//   mem_addr, mem_read, mem_write,
//   mem_wdata                      debug memory request
//   MonDReg                        last read data
//   monitor_ready                  idle and MonDReg valid
//   monitor_error                  sticky timeout flag
//   busy                           sequencer is not in IDLE
module nios2_debug_ocimem_seq #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_d, wr_d, ready_d;
  logic [31:0]       wdata_d, mon_d;

  // jdo[2:0] and jdo[37] carry no information for this block.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] cnt, cnt_d;
  logic        err, err_d;
  assign monitor_error = err;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign monitor_error = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    addr_d  = mem_addr;
    rd_d    = mem_read;
    wr_d    = mem_write;
    wdata_d = mem_wdata;
    mon_d   = MonDReg;
    ready_d = monitor_ready;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
    cnt_d   = cnt;
    err_d   = err;
`endif
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[17 +: ADDR_W];
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
          if (jdo[36]) err_d = 1'b0;
          cnt_d = '0;
`endif
          if (jdo[35]) begin
            rd_d    = 1'b1;
            ready_d = 1'b0;
            state_d = RD;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          wr_d    = 1'b1;
          ready_d = 1'b0;
          state_d = WR;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (take_no_action_ocimem_a) begin
          rd_d    = 1'b1;
          ready_d = 1'b0;
          state_d = RD;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RD, WR: begin
        if (!mem_waitrequest) begin
          if (state == RD) mon_d = mem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = mem_addr + 1'b1;
          state_d = DONE;
        end
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
        else begin
          cnt_d = cnt + 16'd1;
          // Abort on the stall cycle that brings the count to the limit;
          // the address is left pointing at the failed word.
          if (cnt_d == TO_LIM) begin
            if (state == RD) mon_d = 32'hDEADBEEF;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
`endif
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
      cnt           <= '0;
      err           <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      mem_addr      <= addr_d;
      mem_read      <= rd_d;
      mem_write     <= wr_d;
      mem_wdata     <= wdata_d;
      MonDReg       <= mon_d;
      monitor_ready <= ready_d;
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
      cnt           <= cnt_d;
      err           <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_nios2_debug_ocimem_seq.sv
// Directed bench for nios2_debug_ocimem_seq (ADDR_W = 8, TIMEOUT_CYC = 8).
// Inputs change 1 time unit after the rising edge, and outputs are sampled at
// that same point. Each tick therefore shows the result of exactly one clock edge.
module tb_nios2_debug_ocimem_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic [7:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, MonDReg;
  logic        monitor_ready, monitor_error, busy;

  logic [31:0] mem_model [256];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr];

  nios2_debug_ocimem_seq #(.ADDR_W(8), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .mem_rdata(mem_rdata), .mem_waitrequest(mem_waitrequest),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_addr(input logic clr, input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[36] = clr;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_wr(input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    j[34:3] = wd;
    return j;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    mem_model[8'h10] = 32'hCAFE0001;
    mem_model[8'hFF] = 32'hA5A50FF0;
    mem_model[8'h00] = 32'h0BADF00D;

    // Reset held for 3 clocks with every strobe active
    reset_n = 1'b0; jdo = '1; mem_waitrequest = 1'b0;
    take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    tick(); tick(); tick();
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_read",  32'(mem_read), 32'h0);
    chk("rst_write", 32'(mem_write), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_mon",   MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h1);
    chk("rst_err",   32'(monitor_error), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    reset_n = 1'b1; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    tick();

    // Address load with immediate read of word 0x10
    jdo = mk_addr(1'b0, 1'b1, 8'h10); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0;
    chk("ld_read",  32'(mem_read), 32'h1);
    chk("ld_addr",  32'(mem_addr), 32'h10);
    chk("ld_ready", 32'(monitor_ready), 32'h0);
    chk("ld_busy",  32'(busy), 32'h1);
    tick();
    chk("ld_read_drop", 32'(mem_read), 32'h0);
    chk("ld_mon",       MonDReg, 32'hCAFE0001);
    chk("ld_addr_inc",  32'(mem_addr), 32'h11);
    tick();
    chk("ld_ready_back", 32'(monitor_ready), 32'h1);
    chk("ld_idle",       32'(busy), 32'h0);

    // Write with waitrequest high for 4 cycles
    mem_waitrequest = 1'b1;
    jdo = mk_wr(32'h12345678); take_action_ocimem_b = 1'b1;
    tick(); take_action_ocimem_b = 1'b0; jdo = '0;
    chk("wr_write", 32'(mem_write), 32'h1);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    chk("wr_addr",  32'(mem_addr), 32'h11);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_stall_write", 32'(mem_write), 32'h1);
      chk("wr_stall_wdata", mem_wdata, 32'h12345678);
      chk("wr_stall_read",  32'(mem_read), 32'h0);
      chk("wr_stall_addr",  32'(mem_addr), 32'h11);
    end
    mem_waitrequest = 1'b0;
    tick();
    chk("wr_write_drop", 32'(mem_write), 32'h0);
    chk("wr_addr_inc",   32'(mem_addr), 32'h12);
    chk("wr_mon_keep",   MonDReg, 32'hCAFE0001);
    tick();
    chk("wr_ready_back", 32'(monitor_ready), 32'h1);
    chk("wr_idle",       32'(busy), 32'h0);

    // Address 0xFF, read, wrap to 0x00, strobes while busy are dropped
    jdo = mk_addr(1'b0, 1'b0, 8'hFF); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0;
    chk("wrap_ld_addr", 32'(mem_addr), 32'hFF);
    chk("wrap_ld_read", 32'(mem_read), 32'h0);
    chk("wrap_ld_busy", 32'(busy), 32'h0);
    mem_waitrequest = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick();
    chk("wrap_read", 32'(mem_read), 32'h1);
    jdo = mk_addr(1'b0, 1'b1, 8'h40); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; jdo = '0;
    chk("drop_addr", 32'(mem_addr), 32'hFF);
    chk("drop_read", 32'(mem_read), 32'h1);
    mem_waitrequest = 1'b0;
    tick();
    chk("wrap_mon",  MonDReg, 32'hA5A50FF0);
    chk("wrap_addr", 32'(mem_addr), 32'h00);
    chk("wrap_read_drop", 32'(mem_read), 32'h0);
    tick();
    chk("drop_no_read2", 32'(mem_read), 32'h0);
    tick();
    chk("drop_no_read3", 32'(mem_read), 32'h0);
    chk("drop_idle",     32'(busy), 32'h0);
    chk("drop_addr_end", 32'(mem_addr), 32'h00);

    // Read with waitrequest stuck high
    mem_waitrequest = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick(); take_no_action_ocimem_a = 1'b0;
    chk("to_read", 32'(mem_read), 32'h1);
`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_stall_read", 32'(mem_read), 32'h1);
      chk("to_stall_err",  32'(monitor_error), 32'h0);
    end
    tick();
    chk("to_read_drop", 32'(mem_read), 32'h0);
    chk("to_err",       32'(monitor_error), 32'h1);
    chk("to_mon",       MonDReg, 32'hDEADBEEF);
    chk("to_addr",      32'(mem_addr), 32'h00);
    mem_waitrequest = 1'b0;
    tick();
    chk("to_idle",       32'(busy), 32'h0);
    chk("to_err_sticky", 32'(monitor_error), 32'h1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nto_stall_read", 32'(mem_read), 32'h1);
      chk("nto_stall_err",  32'(monitor_error), 32'h0);
    end
    mem_waitrequest = 1'b0;
    tick();
    chk("nto_mon",  MonDReg, 32'h0BADF00D);
    chk("nto_addr", 32'(mem_addr), 32'h01);
    tick();
    chk("nto_idle", 32'(busy), 32'h0);
`endif
    jdo = mk_addr(1'b1, 1'b0, 8'h05); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0; jdo = '0;
    chk("clr_err",  32'(monitor_error), 32'h0);
    chk("clr_addr", 32'(mem_addr), 32'h05);

    // Reset asserted mid-read
    mem_waitrequest = 1'b1;
    jdo = mk_addr(1'b0, 1'b1, 8'h20); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0; jdo = '0;
    chk("mid_read", 32'(mem_read), 32'h1);
    chk("mid_addr", 32'(mem_addr), 32'h20);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_read",  32'(mem_read), 32'h0);
    chk("mid_rst_busy",  32'(busy), 32'h0);
    chk("mid_rst_mon",   MonDReg, 32'h0);
    chk("mid_rst_addr",  32'(mem_addr), 32'h0);
    chk("mid_rst_ready", 32'(monitor_ready), 32'h1);
    reset_n = 1'b1; mem_waitrequest = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_debug_ocimem_seq.md
Name: nios2_debug_ocimem_seq

Overview:
- Sysclk-domain sequencer placed after the debug-slave sysclk synchroniser.
- Turns the one-cycle take_action/take_no_action OCI-memory strobes and the 38-bit jdo word into single-beat read/write transactions on the on-chip debug memory port.
- Handles address auto-increment, the memory wait handshake and timeout.
- Drives MonDReg, monitor_ready and monitor_error back toward the TCK-side capture logic.

Parameters:
- ADDR_W, 8, debug memory word-address width.
- TIMEOUT_CYC, 255, maximum cycles a transaction may hold mem_waitrequest before it is aborted; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- jdo  in  38  JTAG data-out word, valid in the cycle of any strobe.
- take_action_ocimem_a  in  1  strobe: load address from jdo; optional immediate read.
- take_no_action_ocimem_a  in  1  strobe: read at current address, then increment.
- take_action_ocimem_b  in  1  strobe: write jdo[34:3] at current address, then increment.
- mem_rdata  in  32  debug memory read data.
- mem_waitrequest  in  1  memory stall; the request is held while high.
- mem_addr  out  ADDR_W  memory word address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_wdata  out  32  write data.
- MonDReg  out  32  monitor data register (last read data).
- monitor_ready  out  1  high when the sequencer is idle and MonDReg is valid.
- monitor_error  out  1  sticky: a transaction timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: state = IDLE; mem_addr = 0; mem_read = 0; mem_write = 0; mem_wdata = 0; MonDReg = 0; monitor_ready = 1; monitor_error = 0; busy = 0; timeout counter = 0.
- Reset asserted mid-transaction drops mem_read/mem_write in the same edge. No completion is reported.
- States: IDLE, RD, WR, DONE.
- IDLE, strobe priority (only one strobe is acted on per cycle, in this order):
  1. take_action_ocimem_a:
     - mem_addr <= jdo[17 +: ADDR_W].
     - If jdo[35] = 1: go to RD. Otherwise stay in IDLE.
  2. take_action_ocimem_b:
     - mem_wdata <= jdo[34:3].
     - mem_write <= 1; monitor_ready <= 0; go to WR.
  3. take_no_action_ocimem_a:
     - mem_read <= 1; monitor_ready <= 0; go to RD.
  - The address-load path into RD also asserts mem_read and clears monitor_ready on the same edge.
- RD:
  - mem_read stays high while mem_waitrequest = 1.
  - First cycle with mem_waitrequest = 0: MonDReg <= mem_rdata; mem_read <= 0; mem_addr <= mem_addr + 1; go to DONE.
  - Minimum latency, strobe to MonDReg valid: 2 cycles.
- WR:
  - Same handshake as RD.
  - On acceptance: mem_write <= 0; mem_addr <= mem_addr + 1; go to DONE. MonDReg is unchanged.
- DONE: monitor_ready <= 1; go to IDLE in 1 cycle.
- Strobes while busy: ignored, no queueing. Host software guarantees spacing; the bench checks that they are dropped.
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0).
- mem_read and mem_write are never high together.
- monitor_error:
  - Set only by the timeout feature.
  - Cleared by take_action_ocimem_a with jdo[36] = 1. The clear applies in the cycle of the strobe, before any new error.
- busy = (state != IDLE).

Optional Feature:
- Macro: NIOS2_DEBUG_OCIMEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to RD or WR and increments each cycle that mem_waitrequest = 1.
  - When it reaches TIMEOUT_CYC:
    - Drop the request.
    - Set monitor_error.
    - RD abort loads MonDReg <= 32'hDEADBEEF.
    - Do not increment the address.
    - Go to DONE.
- Not defined:
  - No counter logic.
  - RD/WR wait indefinitely.
  - monitor_error is tied to 0.

Test Plan:
- Reset: hold reset_n = 0 for 3 clocks with strobes active -> all outputs at reset values; monitor_ready = 1.
- Address load + read:
  - Stimulus: take_action_ocimem_a, jdo[24:17] = 8'h10, jdo[35] = 1; memory word 0x10 = 32'hCAFE0001; waitrequest low.
  - Response: mem_read high for 1 cycle at addr 0x10; MonDReg = 32'hCAFE0001 two cycles after the strobe; mem_addr = 0x11; monitor_ready back to 1.
- Write with stall:
  - Stimulus: take_action_ocimem_b, jdo[34:3] = 32'h12345678; waitrequest high for 4 cycles.
  - Response: mem_write held 5 cycles, data stable; mem_addr increments once; MonDReg unchanged.
- Wrap and dropped strobe:
  - Stimulus: address 8'hFF, then take_no_action_ocimem_a, plus a second strobe while busy.
  - Response: mem_addr = 0x00 after the read; exactly one read issued.
- Timeout (macro defined, TIMEOUT_CYC = 8):
  - Stimulus: waitrequest stuck high on a read.
  - Response: after 8 stall cycles mem_read drops; monitor_error = 1; MonDReg = 32'hDEADBEEF; address unchanged.
  - Then take_action_ocimem_a with jdo[36] = 1 clears monitor_error.
- Reset mid-read: reset_n low while in RD -> next edge mem_read = 0, state IDLE, MonDReg = 0.
